load_store_unit: RTL and testbench

- Data-memory access stage, directly downstream of the pipeline memory stage.
- Consumes the memory-stage request (valid, address, function, mask type, store data) and runs one access on a ready/valid data bus.
- Returns formatted load data as dmem_out, and drives the cache-miss stall that freezes the pipeline while an access is outstanding.
- Handles sub-word alignment, byte strobes, load sign/zero extension, misalignment detection and a bus timeout.

---
 rtl/load_store_unit_pkg.sv | 45 ++++
 rtl/load_store_unit_align.sv | 42 ++++
 rtl/load_store_unit.sv | 149 ++++++++++++++
 tb/tb_load_store_unit.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared types and constants for the data-memory access stage.
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_ISSUE,
        LSU_WAIT_R,
        LSU_DONE
    } LsuState;

    typedef enum logic [1:0] {
        M_X   = 2'd0,
        M_XRD = 2'd1,
        M_XWR = 2'd2
    } MemoryWriteSignal;

    typedef enum logic [2:0] {
        MT_X  = 3'd0,
        MT_B  = 3'd1,
        MT_H  = 3'd2,
        MT_W  = 3'd3,
        MT_BU = 3'd4,
        MT_HU = 3'd5
    } MemoryMaskType;

    localparam logic [31:0] LSU_ZERO_DATA = 32'h0;

    // Anything that is not a byte or halfword access behaves as a full word.
    function automatic MemoryMaskType norm_typ(input MemoryMaskType t);
        case (t)
            MT_B, MT_BU, MT_H, MT_HU: norm_typ = t;
            default:                  norm_typ = MT_W;
        endcase
    endfunction

    // Halfwords need an even address, words need a word-aligned address.
    function automatic logic is_misaligned(input MemoryMaskType t, input logic [1:0] o);
        case (t)
            MT_H, MT_HU: is_misaligned = o[0];
            MT_W:        is_misaligned = (o != 2'b00);
            default:     is_misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Sub-word steering: store lane replication / byte strobes and load
// lane extraction with sign or zero extension. Purely combinational.
module lsu_align
    import load_store_unit_pkg::*;
(
    input  MemoryMaskType typ,
    input  logic [1:0]    off,
    input  logic [31:0]   st_data,
    input  logic [31:0]   rdata,
    output logic [31:0]   wdata,
    output logic [3:0]    wstrb,
    output logic [31:0]   ldata
);

    logic [31:0] lane;

    // Shift the addressed bytes down to bit 0, then size/extend per type.
    always_comb begin
        lane  = rdata >> {off, 3'b000};
        wdata = st_data;
        wstrb = 4'b1111;
        ldata = rdata;
        case (typ)
            MT_B, MT_BU: begin
                wdata = {4{st_data[7:0]}};
                wstrb = 4'b0001 << off;
                ldata = (typ == MT_B) ? {{24{lane[7]}}, lane[7:0]} : {24'h0, lane[7:0]};
            end
            MT_H, MT_HU: begin
                wdata = {2{st_data[15:0]}};
                wstrb = 4'b0011 << off;
                ldata = (typ == MT_H) ? {{16{lane[15]}}, lane[15:0]} : {16'h0, lane[15:0]};
            end
            default: begin
                wdata = st_data;
                wstrb = 4'b1111;
                ldata = rdata;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access stage: runs one ready/valid bus access per request,
// stalls the pipeline while it is outstanding and returns formatted load data.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic [31:0]      req_addr,
    input  MemoryWriteSignal req_fcn,
    input  MemoryMaskType    req_typ,
    input  logic [31:0]      req_data,
    output logic             res_valid,
    output logic [31:0]      res_data,
    output logic             stall,
    output logic             misaligned,
    output logic             bus_error,
    output logic             bus_req_valid,
    input  logic             bus_req_ready,
    output logic [31:0]      bus_addr,
    output logic             bus_we,
    output logic [3:0]       bus_wstrb,
    output logic [31:0]      bus_wdata,
    input  logic             bus_rvalid,
    input  logic [31:0]      bus_rdata
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    LsuState       state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   data_q, data_d;
    MemoryMaskType typ_q, typ_d;
    logic          we_q, we_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic [31:0]   res_data_q, res_data_d;

    MemoryMaskType in_typ;
    logic [31:0]   al_wdata, al_ldata;
    logic [3:0]    al_wstrb;
    logic          issue;

    assign in_typ = norm_typ(req_typ);
    assign issue  = (state_q == LSU_ISSUE);

    lsu_align u_align (
        .typ     (typ_q),
        .off     (addr_q[1:0]),
        .st_data (data_q),
        .rdata   (bus_rdata),
        .wdata   (al_wdata),
        .wstrb   (al_wstrb),
        .ldata   (al_ldata)
    );

    // Next-state, request latching, timeout counting and pipeline stall.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        typ_d      = typ_q;
        we_d       = we_q;
        cnt_d      = cnt_q;
        err_d      = 1'b0;
        res_data_d = res_data_q;
        stall      = 1'b0;
        misaligned = 1'b0;
        case (state_q)
            LSU_IDLE: begin
                if (req_valid) begin
                    if (is_misaligned(in_typ, req_addr[1:0])) begin
                        misaligned = 1'b1;
                        res_data_d = LSU_ZERO_DATA;
                    end else begin
                        stall   = 1'b1;
                        addr_d  = req_addr;
                        data_d  = req_data;
                        typ_d   = in_typ;
                        we_d    = (req_fcn == M_XWR);
                        cnt_d   = '0;
                        state_d = LSU_ISSUE;
                    end
                end
            end
            LSU_ISSUE: begin
                stall = 1'b1;
                cnt_d = cnt_q + CW'(1);
                if (bus_req_ready) begin
                    state_d = we_q ? LSU_DONE : LSU_WAIT_R;
                end else if (cnt_q == TO_LAST) begin
                    err_d      = 1'b1;
                    res_data_d = LSU_ZERO_DATA;
                    state_d    = LSU_DONE;
                end
            end
            LSU_WAIT_R: begin
                stall = 1'b1;
                cnt_d = cnt_q + CW'(1);
                if (bus_rvalid) begin
                    res_data_d = al_ldata;
                    state_d    = LSU_DONE;
                end else if (cnt_q == TO_LAST) begin
                    err_d      = 1'b1;
                    res_data_d = LSU_ZERO_DATA;
                    state_d    = LSU_DONE;
                end
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    // State and latched request; reset abandons any access in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= LSU_IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            typ_q      <= MT_X;
            we_q       <= 1'b0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            res_data_q <= LSU_ZERO_DATA;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            typ_q      <= typ_d;
            we_q       <= we_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            res_data_q <= res_data_d;
        end
    end

    // Completion is either the DONE cycle or an immediate misaligned reject.
    assign res_valid     = (state_q == LSU_DONE) || misaligned;
    assign res_data      = misaligned ? LSU_ZERO_DATA : res_data_q;
    assign bus_error     = (state_q == LSU_DONE) && err_q;
    assign bus_req_valid = issue;
    assign bus_addr      = issue ? {addr_q[31:2], 2'b00} : 32'h0;
    assign bus_we        = issue && we_q;
    assign bus_wstrb     = (issue && we_q) ? al_wstrb : 4'h0;
    assign bus_wdata     = (issue && we_q) ? al_wdata : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a cycle-level bus responder.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             req_valid = 1'b0;
    logic [31:0]      req_addr = '0;
    MemoryWriteSignal req_fcn = M_X;
    MemoryMaskType    req_typ = MT_X;
    logic [31:0]      req_data = '0;
    logic             res_valid, stall, misaligned, bus_error, bus_req_valid, bus_we;
    logic [31:0]      res_data, bus_addr, bus_wdata;
    logic [3:0]       bus_wstrb;
    logic             bus_req_ready = 1'b0;
    logic             bus_rvalid = 1'b0;
    logic [31:0]      bus_rdata = '0;

    int errors = 0;
    int checks = 0;

    // Results of the last access() call
    int          o_stalls;
    bit          o_done, o_err, o_mis, o_bus, o_unstable;
    logic [31:0] o_rd, o_addr, o_wdata;
    logic [3:0]  o_wstrb;
    logic        o_we;

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_addr(req_addr), .req_fcn(req_fcn),
        .req_typ(req_typ), .req_data(req_data),
        .res_valid(res_valid), .res_data(res_data), .stall(stall),
        .misaligned(misaligned), .bus_error(bus_error),
        .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
        .bus_addr(bus_addr), .bus_we(bus_we), .bus_wstrb(bus_wstrb),
        .bus_wdata(bus_wdata), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    // Present one request in IDLE, then act as the bus: ready after rdy_dly
    // issue cycles, rvalid the cycle after a load handshake (if give_rv).
    task automatic access(input MemoryWriteSignal fcn, input MemoryMaskType typ,
                          input logic [31:0] addr, input logic [31:0] data,
                          input int rdy_dly, input bit give_rv, input logic [31:0] rdata);
        int n_issue = 0;
        bit hs_prev = 0;
        o_stalls = 0; o_done = 0; o_err = 0; o_mis = 0; o_bus = 0; o_unstable = 0;
        o_rd = 'x; o_addr = 'x; o_wdata = 'x; o_wstrb = 'x; o_we = 'x;
        bus_rdata = rdata;
        @(posedge clk); #1;
        req_valid = 1'b1; req_fcn = fcn; req_typ = typ; req_addr = addr; req_data = data;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (stall) o_stalls++;
            if (bus_req_valid) begin
                if (!o_bus) begin
                    o_addr = bus_addr; o_wstrb = bus_wstrb; o_wdata = bus_wdata; o_we = bus_we;
                end else if (bus_addr !== o_addr || bus_wstrb !== o_wstrb ||
                             bus_wdata !== o_wdata || bus_we !== o_we) begin
                    o_unstable = 1;
                end
                o_bus = 1;
                n_issue++;
            end
            if (res_valid) begin
                o_done = 1; o_rd = res_data; o_err = bus_error; o_mis = misaligned;
            end
            bus_rvalid    = give_rv && hs_prev;
            hs_prev       = 0;
            bus_req_ready = bus_req_valid && (n_issue > rdy_dly);
            if (bus_req_valid && bus_req_ready && fcn == M_XRD) hs_prev = 1;
            if (o_done) break;
            @(posedge clk); #1;
            // Garbage on the request port while stalled must be ignored
            req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_typ = MT_B;
            req_data = 32'h5555_5555; req_fcn = M_XRD;
        end
        @(posedge clk); #1;
        bus_req_ready = 1'b0; bus_rvalid = 1'b0; req_valid = 1'b0;
        if (!o_done) begin
            errors++;
            $display("FAIL access_timeout: no res_valid within bound (addr=%h)", addr);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
        checks++; if (res_data !== 32'h0) begin errors++; $display("FAIL reset_res_data: got %h want 0", res_data); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
        checks++; if ({bus_req_valid, bus_we, bus_wstrb, bus_addr, bus_wdata} !== '0) begin
            errors++; $display("FAIL reset_bus: valid=%b we=%b strb=%b addr=%h wdata=%h want all 0",
                               bus_req_valid, bus_we, bus_wstrb, bus_addr, bus_wdata);
        end
        checks++; if ({misaligned, bus_error} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {misaligned, bus_error}); end
        @(posedge clk); #1 reset = 1'b1;
    endtask

    task automatic test_store_byte();
        access(M_XWR, MT_B, 32'h0000_1003, 32'h0000_00AB, 0, 0, 32'h0);
        checks++; if (o_addr !== 32'h0000_1000) begin errors++; $display("FAIL stb_addr: got %h want 00001000", o_addr); end
        checks++; if (o_wstrb !== 4'b1000) begin errors++; $display("FAIL stb_wstrb: got %b want 1000", o_wstrb); end
        checks++; if (o_wdata !== 32'hABAB_ABAB) begin errors++; $display("FAIL stb_wdata: got %h want ababab ab", o_wdata); end
        checks++; if (o_we !== 1'b1) begin errors++; $display("FAIL stb_we: got %b want 1", o_we); end
        checks++; if (o_stalls != 2) begin errors++; $display("FAIL stb_stalls: got %0d want 2", o_stalls); end
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL stb_err: got %b want 0", o_err); end
        @(negedge clk);
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL stb_pulse: res_valid=%b after done, want 0", res_valid); end
    endtask

    task automatic test_load_ext();
        access(M_XRD, MT_H, 32'h0000_2002, 32'h0, 3, 1, 32'h8001_1234);
        checks++; if (o_rd !== 32'hFFFF_8001) begin errors++; $display("FAIL ldh_data: got %h want ffff8001", o_rd); end
        checks++; if (o_stalls != 6) begin errors++; $display("FAIL ldh_stalls: got %0d want 6", o_stalls); end
        checks++; if (o_unstable || o_addr !== 32'h0000_2000 || o_we !== 1'b0) begin
            errors++; $display("FAIL ldh_bus: unstable=%0d addr=%h we=%b want stable 00002000 we=0", o_unstable, o_addr, o_we);
        end
        access(M_XRD, MT_HU, 32'h0000_2002, 32'h0, 0, 1, 32'h8001_1234);
        checks++; if (o_rd !== 32'h0000_8001) begin errors++; $display("FAIL ldhu_data: got %h want 00008001", o_rd); end
        checks++; if (o_stalls != 3) begin errors++; $display("FAIL ldhu_stalls: got %0d want 3", o_stalls); end
        access(M_XRD, MT_BU, 32'h0000_2001, 32'h0, 0, 1, 32'h8001_1234);
        checks++; if (o_rd !== 32'h0000_0012) begin errors++; $display("FAIL ldbu_data: got %h want 00000012", o_rd); end
        access(M_XRD, MT_B, 32'h0000_2003, 32'h0, 1, 1, 32'h8001_1234);
        checks++; if (o_rd !== 32'hFFFF_FF80) begin errors++; $display("FAIL ldb_data: got %h want ffffff80", o_rd); end
    endtask

    task automatic test_misaligned();
        access(M_XRD, MT_W, 32'h0000_3002, 32'h0, 0, 1, 32'h1234_5678);
        checks++; if (o_mis !== 1'b1) begin errors++; $display("FAIL misw_flag: got %b want 1", o_mis); end
        checks++; if (o_rd !== 32'h0) begin errors++; $display("FAIL misw_data: got %h want 0", o_rd); end
        checks++; if (o_stalls != 0) begin errors++; $display("FAIL misw_stall: got %0d want 0", o_stalls); end
        checks++; if (o_bus) begin errors++; $display("FAIL misw_bus: bus_req_valid seen=%0d want 0", o_bus); end
        access(M_XWR, MT_HU, 32'h0000_2003, 32'h0000_BEEF, 0, 0, 32'h0);
        checks++; if (o_mis !== 1'b1 || o_bus) begin errors++; $display("FAIL mish: mis=%b bus=%0d want 1/0", o_mis, o_bus); end
    endtask

    task automatic test_load_word_default();
        // MT_X behaves as a word access
        access(M_XRD, MT_X, 32'h0000_5000, 32'h0, 0, 1, 32'hCAFE_F00D);
        checks++; if (o_rd !== 32'hCAFE_F00D) begin errors++; $display("FAIL ldx_data: got %h want cafef00d", o_rd); end
        // Store keeps the previous load result
        access(M_XWR, MT_H, 32'h0000_6002, 32'h0000_1357, 0, 0, 32'h0);
        checks++; if (o_rd !== 32'hCAFE_F00D) begin errors++; $display("FAIL sth_hold: got %h want cafef00d", o_rd); end
        checks++; if (o_wstrb !== 4'b1100 || o_wdata !== 32'h1357_1357) begin
            errors++; $display("FAIL sth_lane: strb=%b wdata=%h want 1100 13571357", o_wstrb, o_wdata);
        end
    endtask

    task automatic test_timeout_back_to_back();
        access(M_XRD, MT_W, 32'h0000_7000, 32'h0, 0, 0, 32'h0);
        checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL to_rd_err: got %b want 1", o_err); end
        checks++; if (o_rd !== 32'h0) begin errors++; $display("FAIL to_rd_data: got %h want 0", o_rd); end
        checks++; if (o_stalls != 5) begin errors++; $display("FAIL to_rd_stalls: got %0d want 5", o_stalls); end
        access(M_XWR, MT_W, 32'h0000_8000, 32'h1122_3344, 0, 0, 32'h0);
        checks++; if (o_err !== 1'b0 || o_stalls != 2) begin errors++; $display("FAIL b2b_st: err=%b stalls=%0d want 0/2", o_err, o_stalls); end
        checks++; if (o_wstrb !== 4'b1111 || o_wdata !== 32'h1122_3344 || o_addr !== 32'h0000_8000) begin
            errors++; $display("FAIL b2b_bus: strb=%b wdata=%h addr=%h want 1111 11223344 00008000", o_wstrb, o_wdata, o_addr);
        end
        access(M_XWR, MT_W, 32'h0000_9000, 32'h0, 100, 0, 32'h0);
        checks++; if (o_err !== 1'b1 || o_stalls != 5) begin errors++; $display("FAIL to_issue: err=%b stalls=%0d want 1/5", o_err, o_stalls); end
    endtask

    task automatic test_reset_mid_access();
        access(M_XRD, MT_W, 32'h0000_A000, 32'h0, 0, 1, 32'h0BAD_CAFE);
        @(posedge clk); #1;
        req_valid = 1'b1; req_fcn = M_XRD; req_typ = MT_W; req_addr = 32'h0000_B000;
        @(posedge clk); #1;
        req_valid = 1'b0; bus_req_ready = 1'b1;
        @(posedge clk); #1;
        bus_req_ready = 1'b0; bus_rdata = 32'h7777_7777;
        @(negedge clk);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rst_pre_stall: got %b want 1", stall); end
        #1 reset = 1'b0;
        #1;
        checks++; if (stall !== 1'b0 || res_valid !== 1'b0 || res_data !== 32'h0) begin
            errors++; $display("FAIL rst_async: stall=%b res_valid=%b res_data=%h want 0/0/0", stall, res_valid, res_data);
        end
        checks++; if (bus_req_valid !== 1'b0 || bus_addr !== 32'h0) begin
            errors++; $display("FAIL rst_async_bus: valid=%b addr=%h want 0/0", bus_req_valid, bus_addr);
        end
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 bus_rvalid = 1'b1;
        @(negedge clk);
        checks++; if (res_valid !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL rst_stray_rv: res_valid=%b stall=%b want 0/0", res_valid, stall); end
        @(posedge clk); #1 bus_rvalid = 1'b0;
        @(negedge clk);
        checks++; if (res_valid !== 1'b0 || res_data !== 32'h0) begin
            errors++; $display("FAIL rst_stray_data: res_valid=%b res_data=%h want 0/0", res_valid, res_data);
        end
    endtask

    initial begin
        test_reset();
        test_store_byte();
        test_load_ext();
        test_misaligned();
        test_load_word_default();
        test_timeout_back_to_back();
        test_reset_mid_access();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
